seg7_bcd_display: RTL and testbench
===================================

Name: seg7_bcd_display

Overview:
- Consumer end of the tick-counter interface: accepts an 8-bit binary count plus a one-cycle valid strobe from the free-running counter block.
- Converts the count to BCD with a multi-cycle shift-add-3 (double-dabble) FSM.
- Drives three registered seven-segment digits (hundreds/tens/ones) for the board display.

Parameters:
- SEG_ACTIVE_LOW, 1, 1 = segment lit when its bit is 0 (board default); 0 = active-high.
- BLANK_LZ, 1, 1 = blank leading-zero digits (ones digit always shown); 0 = show all digits.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- val_i  input  8  binary value to display, sampled only when val_valid_i=1 in IDLE
- val_valid_i  input  1  one-cycle strobe (the counter's tick)
- busy_o  output  1  high while a conversion is in progress (CONV or LOAD)
- done_o  output  1  one-cycle pulse when segment outputs update
- ovr_o  output  1  sticky: a strobe arrived while busy; cleared only by rst
- seg0_o  output  8  ones digit; bit0=a .. bit6=g, bit7=dp
- seg1_o  output  8  tens digit
- seg2_o  output  8  hundreds digit

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE; busy_o=0, done_o=0, ovr_o=0.
  - seg0_o..seg2_o = all segments off (8'hFF when SEG_ACTIVE_LOW=1, 8'h00 otherwise).
  - Reset overrides everything, including mid-conversion; the partial result is discarded.
- States: IDLE, CONV, LOAD.
- IDLE:
  - busy_o=0.
  - On a posedge with val_valid_i=1: bin<=val_i, bcd(12b)<=0, step<=0, go CONV.
- CONV:
  - busy_o=1.
  - Each cycle, on the current bcd: add 3 to any nibble >=5 (hundreds/tens/ones independently).
  - Then shift {bcd,bin} left by 1 and increment step.
  - After the 8th shift (step==7 processed), go LOAD. Exactly 8 CONV cycles.
- LOAD:
  - busy_o=1.
  - Register the three digits through the decoder into seg*_o; assert done_o for the following cycle; go IDLE.
- Latency: strobe sampled at edge k.
  - Edges k+1..k+8 perform the shifts.
  - seg*_o change and done_o rises at edge k+9; done_o is high for exactly one cycle.
  - Throughput: one conversion per 10 cycles. A strobe on the cycle done_o is high (state already IDLE) is accepted.
- Strobe while busy: ignored, in-flight conversion unaffected, ovr_o<=1 (sticky).
- Segment outputs hold their last value between updates; dp always off.
- Width rules:
  - val_i range 0..255, so the hundreds nibble is at most 2.
  - No truncation; 12-bit bcd suffices.
- Decode, active-high codes {g..a}: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; bit7 (dp)=0. Blank=00. All bits inverted when SEG_ACTIVE_LOW=1.
- Blanking (BLANK_LZ=1):
  - Hundreds blank if 0.
  - Tens blank if hundreds==0 and tens==0.
  - Ones never blank.

Decomposition:
- Package seg7_pkg:
  - state enum (IDLE/CONV/LOAD)
  - SEG_CODE[0:9] constant table, SEG_BLANK
  - BCD_ADJ_THRESH=5, BCD_ADJ=3, CONV_STEPS=8
- One sub-module: seg7_decode, combinational, (4-bit digit, blank, active_low) -> 8-bit segments; instantiated three times before the output registers.

Test Plan (defaults SEG_ACTIVE_LOW=1, BLANK_LZ=1):
- Hold rst 2 cycles -> seg2/1/0=FF/FF/FF, busy_o=0, done_o=0, ovr_o=0.
- val_i=42, strobe 1 cycle at edge k -> busy_o high k+1..k+9, done_o one cycle after edge k+9; seg2/1/0=FF/99/A4.
- val_i=255 -> seg2/1/0=A4/92/92. val_i=0 -> FF/FF/C0; rerun with BLANK_LZ=0 -> C0/C0/C0. val_i=100 -> F9/C0/C0.
- Strobe 42, then strobe 7 at edge k+4 -> result still FF/99/A4, ovr_o=1 and stays 1. Strobe 7 on the done_o cycle -> accepted, outputs FF/FF/F8 ten cycles later.
- Strobe 99, assert rst at edge k+5 -> next cycle busy_o=0, segs FF/FF/FF, ovr_o=0, no done_o. Then strobe 58 -> FF/92/80.
- Drive strobes every 10 cycles with counting values 0..99 -> each done_o shows the matching value and ovr_o stays 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment BCD display block.
// Segment codes are active-high {g..a}; polarity is applied in the decoder.
package seg7_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      LOAD = 2'd2
   } state_t;

   localparam logic [6:0] SEG_CODE [0:9] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   localparam logic [7:0] SEG_BLANK      = 8'h00;
   localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
   localparam logic [3:0] BCD_ADJ        = 4'd3;
   localparam int         CONV_STEPS     = 8;

   // Double-dabble correction applied to one BCD nibble before each shift.
   function automatic logic [3:0] bcd_adjust(input logic [3:0] nib);
      return (nib >= BCD_ADJ_THRESH) ? nib + BCD_ADJ : nib;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to seven-segment decoder with blanking and
// selectable output polarity. dp (bit 7) is always off.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] i_digit,
   input  logic       i_blank,
   input  logic       i_active_low,
   output logic [7:0] o_seg
);

   logic [7:0] w_seg_hi;

   // Non-decimal nibbles cannot occur from the converter; they show blank.
   always_comb begin
      w_seg_hi = SEG_BLANK;
      if (!i_blank && (i_digit <= 4'd9)) begin
         w_seg_hi = {1'b0, SEG_CODE[i_digit]};
      end
   end

   assign o_seg = i_active_low ? ~w_seg_hi : w_seg_hi;

endmodule

// File: rtl/seg7_bcd_display.sv
// Accepts an 8-bit count strobe, converts it to BCD with an 8-step
// double-dabble FSM, and drives three registered seven-segment digits.
module seg7_bcd_display
   import seg7_pkg::*;
#(
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit BLANK_LZ       = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] val_i,
   input  logic       val_valid_i,
   output logic       busy_o,
   output logic       done_o,
   output logic       ovr_o,
   output logic [7:0] seg0_o,
   output logic [7:0] seg1_o,
   output logic [7:0] seg2_o
);

   localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

   state_t      r_state;
   state_t      w_state_next;
   logic [7:0]  r_bin;
   logic [11:0] r_bcd;
   logic [2:0]  r_step;
   logic        r_done;
   logic        r_ovr;
   logic [7:0]  r_seg [0:2];

   logic        w_busy;
   logic [11:0] w_bcd_adj;
   logic [19:0] w_shifted;
   logic [2:0]  w_blank;
   logic [7:0]  w_seg [0:2];

   // Per-nibble correction, then one left shift of the {bcd,bin} pair.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_adj
         assign w_bcd_adj[4*gi +: 4] = bcd_adjust(r_bcd[4*gi +: 4]);
      end
   endgenerate

   assign w_shifted = {w_bcd_adj, r_bin} << 1;

   // Tens blanks only when hundreds is also zero; ones is always shown.
   assign w_blank[0] = 1'b0;
   assign w_blank[1] = BLANK_LZ && (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
   assign w_blank[2] = BLANK_LZ && (r_bcd[11:8] == 4'd0);

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_dec
         seg7_decode u_decode (
            .i_digit      (r_bcd[4*gi +: 4]),
            .i_blank      (w_blank[gi]),
            .i_active_low (SEG_ACTIVE_LOW),
            .o_seg        (w_seg[gi])
         );
      end
   endgenerate

   always_comb begin
      w_state_next = r_state;
      w_busy       = 1'b0;
      case (r_state)
         IDLE: begin
            if (val_valid_i) begin
               w_state_next = CONV;
            end
         end
         CONV: begin
            w_busy = 1'b1;
            if (r_step == 3'(CONV_STEPS - 1)) begin
               w_state_next = LOAD;
            end
         end
         LOAD: begin
            w_busy       = 1'b1;
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_bin   <= '0;
         r_bcd   <= '0;
         r_step  <= '0;
         r_done  <= 1'b0;
         r_ovr   <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            r_seg[i] <= SEG_OFF;
         end
      end else begin
         r_state <= w_state_next;
         r_done  <= 1'b0;
         // A strobe arriving mid-conversion is dropped but remembered.
         if (val_valid_i && (r_state != IDLE)) begin
            r_ovr <= 1'b1;
         end
         case (r_state)
            IDLE: begin
               if (val_valid_i) begin
                  r_bin  <= val_i;
                  r_bcd  <= '0;
                  r_step <= '0;
               end
            end
            CONV: begin
               r_bcd  <= w_shifted[19:8];
               r_bin  <= w_shifted[7:0];
               r_step <= r_step + 3'd1;
            end
            LOAD: begin
               for (int i = 0; i < 3; i++) begin
                  r_seg[i] <= w_seg[i];
               end
               r_done <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign busy_o = w_busy;
   assign done_o = r_done;
   assign ovr_o  = r_ovr;
   assign seg0_o = r_seg[0];
   assign seg1_o = r_seg[1];
   assign seg2_o = r_seg[2];

endmodule

// File: tb/tb_seg7_bcd_display.sv
// Scoreboard bench: stimulus pushes expected {seg2,seg1,seg0} per accepted
// strobe; a monitor pops and compares on every done pulse of two instances.
module tb_seg7_bcd_display;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] val_i = 8'd0;
   logic       val_valid_i = 1'b0;

   logic       busy_a, done_a, ovr_a;
   logic [7:0] seg0_a, seg1_a, seg2_a;
   logic       busy_b, done_b, ovr_b;
   logic [7:0] seg0_b, seg1_b, seg2_b;

   logic [23:0] q_a[$];
   logic [23:0] q_b[$];
   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   seg7_bcd_display dut_a (
      .clk(clk), .rst(rst), .val_i(val_i), .val_valid_i(val_valid_i),
      .busy_o(busy_a), .done_o(done_a), .ovr_o(ovr_a),
      .seg0_o(seg0_a), .seg1_o(seg1_a), .seg2_o(seg2_a)
   );

   seg7_bcd_display #(.SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)) dut_b (
      .clk(clk), .rst(rst), .val_i(val_i), .val_valid_i(val_valid_i),
      .busy_o(busy_b), .done_o(done_b), .ovr_o(ovr_b),
      .seg0_o(seg0_b), .seg1_o(seg1_b), .seg2_o(seg2_b)
   );

   function automatic logic [6:0] code7(input int d);
      case (d)
         0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
         4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
         8: return 7'h7F;  9: return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   // Active-low expected pattern {seg2,seg1,seg0} for a value.
   function automatic logic [23:0] expect_segs(input int v, input bit blz);
      int h, t, o;
      logic [7:0] s2, s1, s0;
      h  = v / 100;
      t  = (v / 10) % 10;
      o  = v % 10;
      s2 = (blz && h == 0) ? 8'h00 : {1'b0, code7(h)};
      s1 = (blz && h == 0 && t == 0) ? 8'h00 : {1'b0, code7(t)};
      s0 = {1'b0, code7(o)};
      return ~{s2, s1, s0};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Strobe is driven from a negedge and sampled at the next posedge (edge k);
   // returns on the negedge right after edge k.
   task automatic send(input logic [7:0] v, input logic [23:0] exp_a, input bit accepted);
      @(negedge clk);
      val_i       = v;
      val_valid_i = 1'b1;
      if (accepted) begin
         q_a.push_back(exp_a);
         q_b.push_back(expect_segs(int'(v), 1'b0));
      end
      @(negedge clk);
      val_valid_i = 1'b0;
   endtask

   // Scoreboard monitor
   initial begin
      logic [23:0] e;
      forever begin
         @(negedge clk);
         if (done_a) begin
            if (q_a.size() == 0) begin
               n_vec++; n_fail++;
               $display("FAIL unexpected_done_a: got segs %h, expected no done", {seg2_a, seg1_a, seg0_a});
            end else begin
               e = q_a.pop_front();
               $display("done A: segs %h (expected %h)", {seg2_a, seg1_a, seg0_a}, e);
               check("segs_a", {8'h00, seg2_a, seg1_a, seg0_a}, {8'h00, e});
            end
         end
         if (done_b) begin
            if (q_b.size() == 0) begin
               n_vec++; n_fail++;
               $display("FAIL unexpected_done_b: got segs %h, expected no done", {seg2_b, seg1_b, seg0_b});
            end else begin
               e = q_b.pop_front();
               $display("done B: segs %h (expected %h)", {seg2_b, seg1_b, seg0_b}, e);
               check("segs_b", {8'h00, seg2_b, seg1_b, seg0_b}, {8'h00, e});
            end
         end
      end
   end

   initial begin
      int nd;
      // Reset held for two edges
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_segs_a", {8'h00, seg2_a, seg1_a, seg0_a}, 32'h00FFFFFF);
      check("rst_segs_b", {8'h00, seg2_b, seg1_b, seg0_b}, 32'h00FFFFFF);
      check("rst_flags", {29'd0, busy_a, done_a, ovr_a}, 32'd0);
      rst = 1'b0;

      // 42 with latency/busy timing, then 7 strobed on the done cycle
      send(8'd42, 24'hFF99A4, 1'b1);
      check("busy_k1", {31'd0, busy_a}, 32'd1);
      for (int i = 2; i <= 9; i++) begin
         @(negedge clk);
         check($sformatf("busy_k%0d", i), {30'd0, busy_a, done_a}, 32'd2);
      end
      @(negedge clk);
      check("done_k9", {30'd0, busy_a, done_a}, 32'd1);
      val_i = 8'd7; val_valid_i = 1'b1;
      q_a.push_back(24'hFFFFF8);
      q_b.push_back(expect_segs(7, 1'b0));
      @(negedge clk);
      val_valid_i = 1'b0;
      check("done_one_cycle", {30'd0, busy_a, done_a}, 32'd2);
      repeat (12) @(negedge clk);

      send(8'd255, 24'hA49292, 1'b1); repeat (12) @(negedge clk);
      send(8'd0,   24'hFFFFC0, 1'b1); repeat (12) @(negedge clk);
      send(8'd100, 24'hF9C0C0, 1'b1); repeat (12) @(negedge clk);

      // Overrun: 7 strobed at edge k+4 is dropped
      send(8'd42, 24'hFF99A4, 1'b1);
      repeat (3) @(negedge clk);
      val_i = 8'd7; val_valid_i = 1'b1;
      @(negedge clk);
      val_valid_i = 1'b0;
      check("ovr_set", {31'd0, ovr_a}, 32'd1);
      repeat (10) @(negedge clk);
      check("ovr_sticky", {31'd0, ovr_a}, 32'd1);

      // Reset mid-conversion at edge k+5
      send(8'd99, 24'h0, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_flags", {29'd0, busy_a, done_a, ovr_a}, 32'd0);
      check("abort_segs", {8'h00, seg2_a, seg1_a, seg0_a}, 32'h00FFFFFF);
      nd = 0;
      repeat (12) begin
         @(negedge clk);
         if (done_a) nd++;
      end
      check("abort_no_done", nd, 0);

      send(8'd58, 24'hFF9280, 1'b1); repeat (12) @(negedge clk);

      // Back-to-back conversions every 10 cycles
      for (int v = 0; v < 100; v++) begin
         send(8'(v), expect_segs(v, 1'b1), 1'b1);
         repeat (8) @(negedge clk);
      end
      for (int i = 0; i < 40 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
      check("drain", q_a.size() + q_b.size(), 0);
      check("sweep_no_ovr", {31'd0, ovr_a}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
